// File: rtl/half_duplex_spi_master_mcs.sv
// Half-duplex 3-wire SPI master with runtime divider, SPI mode, chip-select index
// and a per-bit read/write mask. Data moves MSB-first over one bidirectional SDIO pin.
module half_duplex_spi_master_mcs #(
    parameter int DATA_WIDTH            = 32,
    parameter int TRANSACTION_LEN_WIDTH = 6,
    parameter int NUM_CS                = 4,
    parameter int DIV_WIDTH             = 8,
    parameter int CS_W                  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                             fabric_clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic [TRANSACTION_LEN_WIDTH-1:0] transaction_length,
    input  logic [DATA_WIDTH-1:0]            transaction_data,
    input  logic [DATA_WIDTH-1:0]            transaction_rw_mask,
    input  logic [CS_W-1:0]                  cs_select,
    input  logic [DIV_WIDTH-1:0]             clk_div,
    input  logic                             spi_cpol,
    input  logic                             spi_cpha,
    output logic                             busy,
    output logic                             done,
    output logic [DATA_WIDTH-1:0]            transaction_read_data,
    inout  wire                              spi_sdio,
    output logic                             spi_sclk,
    output logic [NUM_CS-1:0]                spi_cs_n
);
    localparam int IW     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int LW_MIN = $clog2(DATA_WIDTH + 1);
    localparam int LW     = (TRANSACTION_LEN_WIDTH > LW_MIN) ? TRANSACTION_LEN_WIDTH : LW_MIN;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP, S_DONE} state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] data_q, mask_q;
    logic [DIV_WIDTH-1:0]  div_q, div_cnt;
    logic                  cpol_q, cpha_q;
    logic [IW-1:0]         bit_idx;
    logic                  trail;
    logic                  sdio_oe, sdio_out;

    logic [LW-1:0]         len_ext, len_in;
    logic [IW-1:0]         top_in, nxt_idx, lead_idx;
    logic                  noop_in, hp_end;

    // bit_idx names the bit of the current SCLK period; it steps at each leading edge
    always_comb begin
        len_ext  = LW'(transaction_length);
        len_in   = (len_ext > LW'(DATA_WIDTH)) ? LW'(DATA_WIDTH) : len_ext;
        top_in   = IW'(len_in - LW'(1));
        noop_in  = (len_in == '0) || (32'(cs_select) >= NUM_CS);
        nxt_idx  = bit_idx - IW'(1);
        lead_idx = (state == S_SETUP) ? bit_idx : nxt_idx;
        hp_end   = (div_cnt == '0);
    end

    assign spi_sdio = sdio_oe ? sdio_out : 1'bz;

    always_ff @(posedge fabric_clk or negedge reset_n) begin
        if (!reset_n) begin
            state                 <= S_IDLE;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            transaction_read_data <= '0;
            spi_cs_n              <= '1;
            spi_sclk              <= 1'b0;
            sdio_oe               <= 1'b0;
            sdio_out              <= 1'b0;
            data_q                <= '0;
            mask_q                <= '0;
            div_q                 <= '0;
            div_cnt               <= '0;
            cpol_q                <= 1'b0;
            cpha_q                <= 1'b0;
            bit_idx               <= '0;
            trail                 <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    spi_sclk <= spi_cpol;
                    if (start) begin
                        data_q                <= transaction_data;
                        mask_q                <= transaction_rw_mask;
                        div_q                 <= clk_div;
                        div_cnt               <= clk_div;
                        cpol_q                <= spi_cpol;
                        cpha_q                <= spi_cpha;
                        bit_idx               <= top_in;
                        trail                 <= 1'b0;
                        transaction_read_data <= '0;
                        if (noop_in) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= S_SETUP;
                            busy     <= 1'b1;
                            spi_cs_n <= ~(NUM_CS'(1) << cs_select);
                            if (!spi_cpha && !transaction_rw_mask[top_in]) begin
                                sdio_oe  <= 1'b1;
                                sdio_out <= transaction_data[top_in];
                            end
                        end
                    end
                end
                S_SETUP, S_SHIFT: begin
                    if (!hp_end) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        div_cnt <= div_q;
                        if (state == S_SETUP || trail) begin
                            if (state == S_SHIFT && bit_idx == '0) begin
                                state   <= S_HOLD;
                                sdio_oe <= 1'b0;
                            end else begin
                                // leading edge of the next bit period
                                state    <= S_SHIFT;
                                spi_sclk <= ~cpol_q;
                                trail    <= 1'b0;
                                bit_idx  <= lead_idx;
                                if (!cpha_q) begin
                                    if (mask_q[lead_idx])
                                        transaction_read_data[lead_idx] <= spi_sdio;
                                end else begin
                                    sdio_oe  <= ~mask_q[lead_idx];
                                    sdio_out <= data_q[lead_idx];
                                end
                            end
                        end else begin
                            spi_sclk <= cpol_q;
                            trail    <= 1'b1;
                            if (cpha_q) begin
                                if (mask_q[bit_idx])
                                    transaction_read_data[bit_idx] <= spi_sdio;
                            end else if (bit_idx != '0) begin
                                sdio_oe  <= ~mask_q[nxt_idx];
                                sdio_out <= data_q[nxt_idx];
                            end
                        end
                    end
                end
                S_HOLD: begin
                    if (!hp_end) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        div_cnt  <= div_q;
                        spi_cs_n <= '1;
                        state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (!hp_end) begin
                        div_cnt <= div_cnt - 1'b1;
                    end else begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                S_DONE: begin
                    done     <= 1'b0;
                    state    <= S_IDLE;
                    spi_sclk <= spi_cpol;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_half_duplex_spi_master_mcs.sv
// Bench for half_duplex_spi_master_mcs: a pin-level slave model plus a queue of
// expected completions that a separate monitor checks whenever done pulses.
module tb_half_duplex_spi_master_mcs;
    localparam int DW  = 32;
    localparam int LW  = 6;
    localparam int NCS = 5;
    localparam int DVW = 8;
    localparam int CSW = 3;

    typedef struct {
        int             done_cyc;
        logic [31:0]    rd;
        logic [31:0]    wr;
        int             n;
        bit             noop;
        logic [NCS-1:0] cs_n;
        bit             cpol;
        int             frames_before;
    } exp_t;

    logic              fabric_clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              start = 1'b0;
    logic [LW-1:0]     transaction_length = '0;
    logic [DW-1:0]     transaction_data = '0;
    logic [DW-1:0]     transaction_rw_mask = '0;
    logic [CSW-1:0]    cs_select = '0;
    logic [DVW-1:0]    clk_div = '0;
    logic              spi_cpol = 1'b0;
    logic              spi_cpha = 1'b0;
    logic              busy, done;
    logic [DW-1:0]     transaction_read_data;
    wire               spi_sdio;
    logic              spi_sclk;
    logic [NCS-1:0]    spi_cs_n;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t q[$];

    // slave configuration and observations
    int             s_n = 0;
    logic [31:0]    s_mask = '0, s_word = '0;
    bit             s_cpha = 1'b0;
    logic           slv_oe = 1'b0, slv_bit = 1'b0;
    bit             in_frame = 1'b0;
    int             edges = 0, frames = 0, last_edges = 0;
    logic [31:0]    got_wr = '0, last_wr = '0;
    logic [NCS-1:0] frame_cs = '1, last_cs = '1;
    bit             cs_stable = 1'b1, last_stable = 1'b1;
    logic           lvl_start = 1'b0, last_lvl_start = 1'b0, last_lvl_end = 1'b0;
    logic           sclk_prev = 1'b0;

    assign spi_sdio = slv_oe ? slv_bit : 1'bz;

    half_duplex_spi_master_mcs #(
        .DATA_WIDTH(DW), .TRANSACTION_LEN_WIDTH(LW), .NUM_CS(NCS), .DIV_WIDTH(DVW)
    ) dut (
        .fabric_clk(fabric_clk), .reset_n(reset_n), .start(start),
        .transaction_length(transaction_length), .transaction_data(transaction_data),
        .transaction_rw_mask(transaction_rw_mask), .cs_select(cs_select),
        .clk_div(clk_div), .spi_cpol(spi_cpol), .spi_cpha(spi_cpha),
        .busy(busy), .done(done), .transaction_read_data(transaction_read_data),
        .spi_sdio(spi_sdio), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n)
    );

    always #5 fabric_clk = ~fabric_clk;
    always @(posedge fabric_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic slv_drive(input int b);
        logic [4:0] bi;
        bi      = 5'(b);
        slv_oe  = s_mask[bi];
        slv_bit = s_word[bi];
    endtask

    // Slave: counts SCLK edges inside a CS-low frame, drives read bits, captures write bits
    initial begin
        int         b;
        bit         lead;
        logic [4:0] bi;
        forever begin
            @(negedge fabric_clk);
            if (!reset_n) begin
                in_frame = 1'b0;
                slv_oe   = 1'b0;
            end else if (spi_cs_n != '1) begin
                if (!in_frame) begin
                    in_frame  = 1'b1;
                    edges     = 0;
                    got_wr    = '0;
                    frame_cs  = spi_cs_n;
                    cs_stable = 1'b1;
                    lvl_start = spi_sclk;
                    if (!s_cpha) slv_drive(s_n - 1);
                end else begin
                    if (spi_cs_n != frame_cs) cs_stable = 1'b0;
                    if (spi_sclk != sclk_prev) begin
                        edges++;
                        lead = (edges % 2) == 1;
                        b    = s_n - 1 - (edges - 1) / 2;
                        if (b >= 0) begin
                            bi = 5'(b);
                            if (lead != s_cpha) begin
                                if (!s_mask[bi]) got_wr[bi] = spi_sdio;
                            end else if (s_cpha) begin
                                slv_drive(b);
                            end else if (b > 0) begin
                                slv_drive(b - 1);
                            end else begin
                                slv_oe = 1'b0;
                            end
                        end
                    end
                end
            end else if (in_frame) begin
                in_frame       = 1'b0;
                slv_oe         = 1'b0;
                frames++;
                last_edges     = edges;
                last_wr        = got_wr;
                last_cs        = frame_cs;
                last_stable    = cs_stable;
                last_lvl_start = lvl_start;
                last_lvl_end   = spi_sclk;
            end
            sclk_prev = spi_sclk;
        end
    end

    // Monitor: every done pulse retires the oldest expected transaction
    initial begin
        exp_t e;
        forever begin
            @(negedge fabric_clk);
            if (reset_n && done) begin
                check("done_has_request", 64'(q.size() > 0), 64'(1));
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("done_cycle", 64'(cyc), 64'(e.done_cyc));
                    check("read_data", 64'(transaction_read_data), 64'(e.rd));
                    check("busy_at_done", 64'(busy), 64'(0));
                    if (e.noop) begin
                        check("noop_no_cs", 64'(frames), 64'(e.frames_before));
                    end else begin
                        check("frame_count", 64'(frames), 64'(e.frames_before + 1));
                        check("sclk_edges", 64'(last_edges), 64'(2 * e.n));
                        check("write_bits", 64'(last_wr), 64'(e.wr));
                        check("cs_pattern", 64'({last_stable, last_cs}), 64'({1'b1, e.cs_n}));
                        check("sclk_idle", 64'({last_lvl_start, last_lvl_end}), 64'({e.cpol, e.cpol}));
                    end
                end
            end
        end
    end

    // Called at a negedge with the DUT idle; returns one cycle after done.
    task automatic issue(input int len, input logic [31:0] data, input logic [31:0] mask,
                         input int sel, input int div, input bit cpol, input bit cpha,
                         input logic [31:0] word, input bit poke);
        exp_t        e;
        int          n, lim;
        logic [31:0] nm;
        n          = (len > DW) ? DW : len;
        nm         = (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
        e.n        = n;
        e.noop     = (n == 0) || (sel >= NCS);
        e.rd       = e.noop ? 32'h0 : (word & mask & nm);
        e.wr       = e.noop ? 32'h0 : (data & ~mask & nm);
        e.cs_n     = ~(NCS'(1) << sel);
        e.cpol     = cpol;
        e.done_cyc = cyc + 1 + (e.noop ? 0 : (2 * n + 3) * (div + 1));
        e.frames_before = frames;
        s_n = n; s_mask = mask; s_word = word; s_cpha = cpha;
        transaction_length  = LW'(len);
        transaction_data    = data;
        transaction_rw_mask = mask;
        cs_select           = CSW'(sel);
        clk_div             = DVW'(div);
        spi_cpol            = cpol;
        spi_cpha            = cpha;
        start               = 1'b1;
        q.push_back(e);
        @(negedge fabric_clk);
        start = 1'b0;
        check("busy_after_accept", 64'(busy), 64'(!e.noop));
        transaction_length  = LW'($urandom);
        transaction_data    = $urandom;
        transaction_rw_mask = $urandom;
        cs_select           = CSW'($urandom);
        clk_div             = DVW'($urandom);
        spi_cpol            = 1'($urandom_range(0, 1));
        spi_cpha            = 1'($urandom_range(0, 1));
        if (poke) begin
            transaction_length = 6'd4;
            cs_select          = '0;
            start              = 1'b1;
            repeat (3) @(negedge fabric_clk);
            start = 1'b0;
        end
        lim = e.done_cyc - cyc + 8;
        while (!done && lim > 0) begin
            @(negedge fabric_clk);
            lim--;
        end
        if (!done) begin
            check("done_timeout", 64'(done), 64'(1));
            q.delete();
        end
        @(negedge fabric_clk);
    endtask

    initial begin
        int lim;
        repeat (3) @(negedge fabric_clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_read_data", 64'(transaction_read_data), 64'(0));
        check("rst_cs_n", 64'(spi_cs_n), 64'({NCS{1'b1}}));
        check("rst_sclk", 64'(spi_sclk), 64'(0));
        reset_n = 1'b1;
        @(negedge fabric_clk);

        issue(8, 32'hA5, 32'h0, 2, 1, 1'b0, 1'b0, 32'h0, 1'b0);
        issue(16, 32'h8000, 32'h00FF, 0, 1, 1'b0, 1'b0, 32'h3C, 1'b0);
        for (int m = 1; m < 4; m++)
            issue(8, $urandom, 32'hFF, m, 2, 1'((m >> 1) & 1), 1'(m & 1), $urandom, 1'b0);
        issue(0, $urandom, $urandom, 1, 1, 1'b0, 1'b0, $urandom, 1'b0);
        issue(63, $urandom, $urandom, 3, 0, 1'b1, 1'b1, $urandom, 1'b0);
        issue(8, $urandom, 32'h0, 5, 0, 1'b0, 1'b0, $urandom, 1'b0);
        issue(32, $urandom, $urandom, 4, 1, 1'b0, 1'b1, $urandom, 1'b1);
        issue(4, $urandom, $urandom, 1, 0, 1'b1, 1'b0, $urandom, 1'b0);
        issue(4, $urandom, $urandom, 2, 255, 1'b0, 1'b1, $urandom, 1'b0);

        // reset in the middle of bit 5 of a 16-bit write
        s_n = 16; s_mask = '0; s_word = '0; s_cpha = 1'b0;
        transaction_length  = 6'd16;
        transaction_data    = 32'hFFFF;
        transaction_rw_mask = '0;
        cs_select           = 3'd1;
        clk_div             = 8'd2;
        spi_cpol            = 1'b0;
        spi_cpha            = 1'b0;
        start               = 1'b1;
        @(negedge fabric_clk);
        start = 1'b0;
        lim = 400;
        while (!(in_frame && edges >= 21) && lim > 0) begin
            @(negedge fabric_clk);
            lim--;
        end
        check("reached_bit5", 64'(in_frame && edges >= 21), 64'(1));
        #2 reset_n = 1'b0;
        #1;
        check("midrst_cs_n", 64'(spi_cs_n), 64'({NCS{1'b1}}));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        @(negedge fabric_clk);
        reset_n = 1'b1;
        @(negedge fabric_clk);
        check("midrst_read_data", 64'(transaction_read_data), 64'(0));
        issue(12, $urandom, $urandom, 0, 1, 1'b1, 1'b1, $urandom, 1'b0);

        for (int i = 0; i < 16; i++)
            issue(int'($urandom_range(0, 40)), $urandom, $urandom, int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom, 1'b0);

        repeat (4) @(negedge fabric_clk);
        check("queue_drained", 64'(q.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
